// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage data memory initiator.
package mem_access_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR,
    ST_RESP
  } state_t;

  // Rejects size 11, odd half addresses and any unaligned word address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    is_misaligned = (size == 2'b11) ||
                    ((size == SZ_HALF) && offset[0]) ||
                    ((size == SZ_WORD) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction with extension for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              is_unsigned,
  input  logic [WORD_W-1:0] rd_word,
  input  logic [WORD_W-1:0] st_data,
  output logic [WORD_W-1:0] ld_value,
  output logic [WORD_W-1:0] st_word
);

  logic [4:0]        byte_lsb;
  logic [4:0]        half_lsb;
  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;

  assign byte_lsb  = {offset, 3'b000};
  assign half_lsb  = {offset[1], 4'b0000};
  assign byte_lane = rd_word[byte_lsb +: BYTE_W];
  assign half_lane = rd_word[half_lsb +: HALF_W];

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    ld_value = rd_word;
    st_word  = st_data;
    case (size)
      SZ_BYTE: begin
        ld_value = is_unsigned ? {{(WORD_W-BYTE_W){1'b0}}, byte_lane}
                               : {{(WORD_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
        st_word  = rd_word;
        st_word[byte_lsb +: BYTE_W] = st_data[BYTE_W-1:0];
      end
      SZ_HALF: begin
        ld_value = is_unsigned ? {{(WORD_W-HALF_W){1'b0}}, half_lane}
                               : {{(WORD_W-HALF_W){half_lane[HALF_W-1]}}, half_lane};
        st_word  = rd_word;
        st_word[half_lsb +: HALF_W] = st_data[HALF_W-1:0];
      end
      default: begin
        ld_value = rd_word;
        st_word  = st_data;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: sequences loads, stores and sub-word read-modify-write on a
// single-port word memory and stalls the pipeline while a transaction is in flight.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              wr_q, wr_d;
  logic              mis_q, mis_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;

  logic              accept;
  logic [31:0]       ld_value;
  logic [31:0]       st_word;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  mem_lane_align u_align (
    .size       (size_q),
    .offset     (off_q),
    .is_unsigned(uns_q),
    .rd_word    (mem_rdata),
    .st_data    (wdata_q),
    .ld_value   (ld_value),
    .st_word    (st_word)
  );

  assign accept = (state_q == ST_IDLE) && req_valid && (req_read ^ req_write);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wr_d    = wr_q;
    mis_d   = mis_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // NOTE: blocking assignments here so mis_d can be read back below in the same pass.
          addr_d  = req_addr[ADDR_W+1:2];
          off_d   = req_addr[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wr_d    = req_write;
          wdata_d = req_wdata;
          data_d  = '0;
          cnt_d   = CNT_INIT;
          mis_d   = is_misaligned(req_size, req_addr[1:0]);
          if (mis_d)                                 state_d = ST_RESP;
          else if (req_write && req_size == SZ_WORD) state_d = ST_WR;
          else                                       state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        // The read word is consumed straight off mem_rdata on the final wait edge.
        if (cnt_q == 3'd0) begin
          if (wr_q) begin
            wdata_d = st_word;
            state_d = ST_WR;
          end else begin
            data_d  = ld_value;
            state_d = ST_RESP;
          end
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wr_q    <= wr_d;
      mis_q   <= mis_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
    end
  end

  assign stall      = (state_q == ST_RD_WAIT) || (state_q == ST_WR);
  assign resp_valid = (state_q == ST_RESP);
  assign misalign   = resp_valid && mis_q;
  assign resp_data  = resp_valid ? data_q : '0;
  assign mem_read   = (state_q == ST_RD_WAIT);
  assign mem_write  = (state_q == ST_WR);
  assign mem_wdata  = mem_write ? wdata_q : '0;
  assign mem_addr   = addr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, hand-written corner
// sequences and randomized requests scored against a behavioural memory model.
module tb_mem_access_unit;

  localparam int ADDR_W = 5;
  localparam int RD_LAT = 1;
  localparam int NWORDS = 1 << ADDR_W;
  localparam int TMO    = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_read, req_write, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              stall, resp_valid, misalign, mem_read, mem_write;
  logic [31:0]       resp_data, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .misalign    (misalign),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory with single-cycle read data; preload port shares the write process.
  logic [31:0] mem [NWORDS];
  logic        pl_en = 1'b0;
  int          pl_idx = 0;
  logic [31:0] pl_val = '0;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  int mon_rd = 0, mon_wr = 0, mon_ovl = 0, mon_stall = 0;
  always @(negedge clk) begin
    if (mem_read) mon_rd++;
    if (mem_write) mon_wr++;
    if (mem_read && mem_write) mon_ovl++;
    if (stall) mon_stall++;
  end

  logic [31:0] model_mem [NWORDS];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    @(posedge clk); #1;
    pl_en = 1'b0;
    model_mem[idx] = val;
  endtask

  function automatic int word_idx(input logic [31:0] addr);
    return int'((addr >> 2) & 32'(NWORDS - 1));
  endfunction

  // Reference behaviour derived from the access rules, not the state machine.
  function automatic void model(input logic rd, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] old_word, output logic [31:0] e_data,
                                output logic e_mis, output int e_lat, output logic [31:0] new_word,
                                output int e_rd, output int e_wr);
    int off, shift, width;
    logic [31:0] mask, v;
    off   = int'(addr % 4);
    shift = 8 * off;
    width = (sz == 2'd0) ? 8 : 16;
    mask  = (width == 8) ? 32'hFF : 32'hFFFF;
    e_data = 0; e_mis = 0; e_lat = 0; new_word = old_word; e_rd = 0; e_wr = 0;
    if (rd == wr) return;
    e_mis = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
    if (e_mis) begin
      e_lat = 1;
    end else if (rd) begin
      e_lat = RD_LAT + 1;
      e_rd  = RD_LAT;
      if (sz == 2'd2) e_data = old_word;
      else begin
        v = (old_word >> shift) & mask;
        if (!uns && ((v >> (width - 1)) & 32'd1) != 0) v = v | ~mask;
        e_data = v;
      end
    end else if (sz == 2'd2) begin
      e_lat = 2; e_wr = 1; new_word = wd;
    end else begin
      e_lat = RD_LAT + 2; e_rd = RD_LAT; e_wr = 1;
      new_word = (old_word & ~(mask << shift)) | ((wd & mask) << shift);
    end
  endfunction

  // Issues one request and measures latency, response and strobe activity.
  task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] g_data, output logic g_mis, output int g_lat,
                        output int g_rd, output int g_wr, output int g_ovl, output int g_stall,
                        output logic g_resp2);
    int b_rd, b_wr, b_ovl, b_st;
    @(posedge clk); #1;
    b_rd = mon_rd; b_wr = mon_wr; b_ovl = mon_ovl; b_st = mon_stall;
    @(negedge clk);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
    req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    g_lat = 0; g_data = '0; g_mis = 1'b0; g_resp2 = 1'b0;
    for (int c = 1; c <= TMO; c++) begin
      if (resp_valid) begin
        g_lat = c; g_data = resp_data; g_mis = misalign;
        break;
      end
      @(posedge clk); #1;
    end
    if (g_lat != 0) begin
      @(posedge clk); #1;
      g_resp2 = resp_valid;
    end
    g_rd = mon_rd - b_rd; g_wr = mon_wr - b_wr; g_ovl = mon_ovl - b_ovl; g_stall = mon_stall - b_st;
  endtask

  task automatic run_and_check(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] x_data, input logic x_mis, input int x_lat,
                               input logic [31:0] x_word);
    logic [31:0] g_data, m_data, m_word;
    logic        g_mis, m_mis, g_resp2;
    int g_lat, g_rd, g_wr, g_ovl, g_st, m_lat, m_rd, m_wr, idx;
    idx = word_idx(addr);
    model(rd, wr, sz, uns, addr, wd, model_mem[idx], m_data, m_mis, m_lat, m_word, m_rd, m_wr);
    do_req(rd, wr, sz, uns, addr, wd, g_data, g_mis, g_lat, g_rd, g_wr, g_ovl, g_st, g_resp2);
    check({nm, ".lat"},   32'(g_lat), 32'(x_lat));
    check({nm, ".data"},  g_data, x_data);
    check({nm, ".mis"},   32'(g_mis), 32'(x_mis));
    check({nm, ".word"},  mem[idx], x_word);
    check({nm, ".rd"},    32'(g_rd), 32'(m_rd));
    check({nm, ".wr"},    32'(g_wr), 32'(m_wr));
    check({nm, ".ovl"},   32'(g_ovl), 32'd0);
    check({nm, ".stall"}, 32'(g_st), (x_lat == 0) ? 32'd0 : 32'(x_lat - 1));
    if (x_lat != 0) check({nm, ".pulse"}, 32'(g_resp2), 32'd0);
    model_mem[idx] = m_word;
  endtask

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr, wdata, init_word, exp_data;
    logic        exp_mis;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{"ld_word",   1, 0, 2'd2, 0, 32'h04, 32'h0,      32'h00000002, 32'h00000002, 0, 2, 32'h00000002};
    vecs[1]  = '{"ld_sbyte",  1, 0, 2'd0, 0, 32'h03, 32'h0,      32'h80FF0001, 32'hFFFFFF80, 0, 2, 32'h80FF0001};
    vecs[2]  = '{"ld_ubyte",  1, 0, 2'd0, 1, 32'h03, 32'h0,      32'h80FF0001, 32'h00000080, 0, 2, 32'h80FF0001};
    vecs[3]  = '{"st_byte",   0, 1, 2'd0, 0, 32'h05, 32'hAB,     32'h11223344, 32'h00000000, 0, 3, 32'h1122AB44};
    vecs[4]  = '{"ld_mis_hw", 1, 0, 2'd1, 0, 32'h07, 32'h0,      32'h12345678, 32'h00000000, 1, 1, 32'h12345678};
    vecs[5]  = '{"ld_shalf",  1, 0, 2'd1, 0, 32'h02, 32'h0,      32'h80017FFF, 32'hFFFF8001, 0, 2, 32'h80017FFF};
    vecs[6]  = '{"st_half",   0, 1, 2'd1, 0, 32'h06, 32'h5A5ABEEF, 32'h11223344, 32'h00000000, 0, 3, 32'hBEEF3344};
    vecs[7]  = '{"st_mis_w",  0, 1, 2'd2, 0, 32'h0A, 32'hFFFFFFFF, 32'h01020304, 32'h00000000, 1, 1, 32'h01020304};
    vecs[8]  = '{"ld_sz11",   1, 0, 2'd3, 0, 32'h00, 32'h0,      32'h0000FFFF, 32'h00000000, 1, 1, 32'h0000FFFF};
    vecs[9]  = '{"ld_wrap",   1, 0, 2'd2, 0, 32'hFFFFFF84, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 0, 2, 32'hCAFEF00D};
    vecs[10] = '{"ignored",   1, 1, 2'd2, 0, 32'h10, 32'h77777777, 32'h0BADF00D, 32'h00000000, 0, 0, 32'h0BADF00D};

    reset = 1'b1;
    req_valid = 0; req_read = 0; req_write = 0; req_size = 0;
    req_unsigned = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < NWORDS; i++) model_mem[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst.state", {stall, resp_valid, misalign, mem_read, mem_write}, 32'd0);
    check("rst.data",  resp_data, 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);
    check("rst.addr",  32'(mem_addr), 32'd0);
    @(negedge clk) reset = 1'b0;

    for (int i = 0; i < NWORDS; i++) preload(i, $urandom);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      preload(word_idx(vecs[i].addr), vecs[i].init_word);
      run_and_check(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_mis, vecs[i].exp_lat, vecs[i].exp_word);
    end

    // Word store followed by a load held during the stall: load accepted only after RESP.
    begin
      int got_lat;
      @(posedge clk); #1;
      @(negedge clk);
      req_valid = 1; req_read = 0; req_write = 1; req_size = 2'd2; req_unsigned = 0;
      req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      req_read = 1; req_write = 0; req_wdata = 32'h0;
      check("b2b.wr_stall", 32'(stall && mem_write), 32'd1);
      @(posedge clk); #1;
      check("b2b.st_resp", 32'(resp_valid), 32'd1);
      check("b2b.no_rd_resp", 32'(mem_read), 32'd0);
      @(posedge clk); #1;
      check("b2b.idle", {stall, resp_valid, mem_read}, 32'd0);
      @(posedge clk); #1;
      req_valid = 0;
      check("b2b.ld_accept", 32'(stall && mem_read), 32'd1);
      got_lat = 0;
      for (int c = 1; c <= TMO; c++) begin
        @(posedge clk); #1;
        if (resp_valid) begin got_lat = c; break; end
      end
      check("b2b.ld_lat", 32'(got_lat), 32'(RD_LAT));
      check("b2b.ld_data", resp_data, 32'hDEADBEEF);
      model_mem[2] = 32'hDEADBEEF;
    end

    // Reset during the read phase of a sub-word store: write must never issue.
    begin
      int b_wr;
      preload(2, 32'h55667788);
      @(posedge clk); #1;
      b_wr = mon_wr;
      @(negedge clk);
      req_valid = 1; req_read = 0; req_write = 1; req_size = 2'd0;
      req_addr = 32'h9; req_wdata = 32'h11;
      @(posedge clk); #1;
      req_valid = 0;
      check("rstmid.in_rd", 32'(stall && mem_read), 32'd1);
      reset = 1'b1;
      #1;
      check("rstmid.ctl", {stall, resp_valid, misalign, mem_read, mem_write}, 32'd0);
      check("rstmid.outs", resp_data | mem_wdata | 32'(mem_addr), 32'd0);
      @(negedge clk) reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rstmid.nowr", 32'(mon_wr - b_wr), 32'd0);
      check("rstmid.word", mem[2], 32'h55667788);
    end

    // Randomized requests scored against the model
    for (int n = 0; n < 150; n++) begin
      logic rd, wr, uns;
      logic [1:0] sz;
      logic [31:0] addr, wd, e_data, e_word;
      logic e_mis;
      int e_lat, e_rd, e_wr, idx;
      rd   = 1'($urandom);
      wr   = ($urandom_range(0, 15) == 0) ? rd : !rd;
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      uns  = 1'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = (sz == 2'd2) ? 2'b00 : (sz == 2'd1) ? {addr[1], 1'b0} : addr[1:0];
      wd   = $urandom;
      idx  = word_idx(addr);
      model(rd, wr, sz, uns, addr, wd, model_mem[idx], e_data, e_mis, e_lat, e_word, e_rd, e_wr);
      run_and_check($sformatf("rnd%0d", n), rd, wr, sz, uns, addr, wd, e_data, e_mis, e_lat, e_word);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator that drives the single-port word-addressed data memory on behalf of the pipeline.
- Accepts load/store requests with byte/half/word size.
- Performs byte-lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores.
- Stalls the pipeline while a memory transaction is in flight.

Parameters:
- ADDR_W, 5, word-index width driven to memory (32 words).
- RD_LAT, 1, cycles from mem_read assertion to valid mem_rdata; legal range 1..7.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present from EX/MEM register
- req_read  input  1  load request
- req_write  input  1  store request
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- stall  output  1  pipeline must hold; request not yet complete
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  extended load data; 0 for stores and errors
- misalign  output  1  valid with resp_valid; request rejected
- mem_addr  output  ADDR_W  word index, req_addr[ADDR_W+1:2]
- mem_wdata  output  32  full word to write
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_rdata  input  32  memory read data

Behaviour:
- Reset (async): state IDLE. stall, resp_valid, resp_data, misalign, mem_read, mem_write, mem_wdata, mem_addr all 0. Reset mid-transaction aborts immediately; a pending write is not issued.
- States: IDLE, RD_WAIT, WR, RESP.
- Accept: in IDLE with req_valid=1 and exactly one of req_read/req_write set. Address, size, data and extend mode are registered at accept.
- req_valid with both or neither strobe set is ignored: no response, state stays IDLE.
- Misalign:
  - Half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - Goes IDLE->RESP with misalign=1 and resp_data=0. No memory strobe.
- Word load / sub-word store: IDLE->RD_WAIT.
  - mem_read=1 for RD_LAT cycles, tracked by a down-counter.
  - mem_rdata is captured on the last RD_WAIT edge.
- Word load: RD_WAIT->RESP.
- Sub-word store: RD_WAIT->WR. The captured word is merged with the new lane(s).
- Word store: IDLE->WR directly.
- WR: mem_write=1 for exactly one cycle, mem_wdata = merged or full word. Then WR->RESP.
- RESP: resp_valid=1 for one cycle, stall=0, then ->IDLE. A new request may be accepted in the cycle after RESP, not during it.
- stall=1 in RD_WAIT and WR. It is registered-state-derived only, with no combinational path from req_valid.
- Latency from the accept edge to resp_valid:
  - misalign: 1 cycle
  - word store: 2 cycles
  - load: RD_LAT+1 cycles
  - sub-word store: RD_LAT+2 cycles
- Lanes are little-endian:
  - byte offset k occupies bits [8k+7:8k]
  - half at offset 0 occupies [15:0], at offset 2 occupies [31:16]
- Loads: the selected lane is right-aligned and extended per req_unsigned. Word loads ignore req_unsigned.
- Store merge replaces only the addressed lane(s) with the low bits of req_wdata. Other bits come from the read word.
- mem_read and mem_write are never high simultaneously.
- mem_addr is stable from the accept edge through RESP.
- req_* changes while not in IDLE are ignored.
- Address bits above ADDR_W+1 are dropped; indices wrap modulo 2^ADDR_W.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
  - the state enum
  - the lane-extract and lane-merge functions' width constants
- One combinational sub-module, mem_lane_align:
  - inputs: size, offset, unsigned flag, read word, store data
  - outputs: extended load value, merged store word
- The FSM and counter stay in mem_access_unit.

Test Plan:
- Word load, RD_LAT=1, addr 0x4, memory word 1 = 0x00000002 -> mem_read high 1 cycle, resp_valid 2 cycles after accept, resp_data=0x00000002, misalign=0.
- Signed byte load, addr 0x3, word 0 = 0x80FF0001 -> resp_data=0xFFFFFF80; the same access with req_unsigned=1 -> 0x00000080.
- Byte store 0xAB to addr 0x5, word 1 = 0x11223344:
  - read cycle, then one mem_write with mem_wdata=0x1122AB44
  - resp_valid at accept+3
  - mem_read and mem_write never overlap
- Misaligned half load at addr 0x7 -> resp_valid next cycle with misalign=1, resp_data=0, no mem_read/mem_write pulse.
- Word store 0xDEADBEEF at addr 0x8, then back-to-back word load of 0x8 presented while stall=1 -> load accepted only after RESP, returns 0xDEADBEEF.
- Reset asserted during RD_WAIT of a sub-word store -> all outputs 0 immediately, no mem_write ever issued, memory word unchanged.
